display_scheduler: RTL

Time-shares the 5-digit seven-segment display datapath between four 16-bit value sources. Arbitrates requests round-robin, latches the granted source's value onto a single registered `value_out` bus for the display's BCD/scan path, and enforces a minimum dwell time per grant. Also generates the free-running scan-enable tick that paces digit multiplexing. Sits between application blocks (counters, ALU results, debug registers) and the display driver.

---
 rtl/display_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/display_scheduler.sv
// Round-robin display time-share: grants one of four sources with a minimum dwell and a scan tick.
// Optional macro DISP_SCHED_BLANK_EN drives blank high whenever no source owns the display.
module display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned SCAN_DIV     = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [15:0] val3,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [15:0] value_out,
    output logic        blank,
    output logic        scan_tick,
    output logic        busy
);

    localparam int unsigned     SCAN_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [23:0]     DWELL_LOAD = 24'(DWELL_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [3:0]        done_q, done_d;
    logic [15:0]       value_q, value_d;
    logic [23:0]       dwell_q, dwell_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic              tick_q, tick_d;

    logic              arb_hit;
    logic [1:0]        arb_idx;
    logic [15:0]       arb_val;
    logic              dwell_end;
    logic              take;

    // Search starts one past the last owner, so the owner itself is considered last.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!arb_hit && req[2'(ptr_q + 2'(i))]) begin
                arb_hit = 1'b1;
                arb_idx = 2'(ptr_q + 2'(i));
            end
        end
    end

    always_comb begin
        case (arb_idx)
            2'd0:    arb_val = val0;
            2'd1:    arb_val = val1;
            2'd2:    arb_val = val2;
            default: arb_val = val3;
        endcase
    end

    assign dwell_end = (state_q == SHOW) && (dwell_q == '0);
    assign take      = ((state_q == IDLE) || dwell_end) && arb_hit;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            value_q <= '0;
            dwell_q <= '0;
            ptr_q   <= 2'd3;
            scan_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            value_q <= value_d;
            dwell_q <= dwell_d;
            ptr_q   <= ptr_d;
            scan_q  <= scan_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_hit) state_d = SHOW;
            SHOW:    if (dwell_end && !arb_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every next-state value gets a default first so no latch is inferred.
    always_comb begin
        grant_d = grant_q;
        done_d  = '0;
        value_d = value_q;
        dwell_d = dwell_q;
        ptr_d   = ptr_q;

        if ((state_q == SHOW) && !dwell_end) begin
            dwell_d = dwell_q - 24'd1;
        end
        if (dwell_end) begin
            done_d  = grant_q;
            grant_d = '0;
        end
        if (take) begin
            grant_d = 4'b0001 << arb_idx;
            value_d = arb_val;
            dwell_d = DWELL_LOAD;
            ptr_d   = arb_idx;
        end

        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        tick_d = (scan_q == SCAN_LAST);
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign value_out = value_q;
    assign scan_tick = tick_q;
    assign busy      = (state_q == SHOW);

`ifdef DISP_SCHED_BLANK_EN
    assign blank = (state_q != SHOW);
`else
    assign blank = 1'b0;
`endif

endmodule
